// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED output PIO: register word addresses and the
// address type used on the slave port.
package led_pio_pkg;

  typedef logic [2:0] led_addr_t;

  localparam led_addr_t LED_ADDR_DATA   = 3'd0;
  localparam led_addr_t LED_ADDR_SET    = 3'd1;
  localparam led_addr_t LED_ADDR_CLR    = 3'd2;
  localparam led_addr_t LED_ADDR_MODE   = 3'd3;
  localparam led_addr_t LED_ADDR_PERIOD = 3'd4;
  localparam led_addr_t LED_ADDR_STATUS = 3'd5;
  localparam led_addr_t LED_ADDR_TOGGLE = 3'd6;
  localparam led_addr_t LED_ADDR_RSVD   = 3'd7;

endpackage

// File: rtl/led_blink_prescaler.sv
// Blink prescaler: free-running counter that inverts phase every period+1
// cycles. A zero period parks the counter at 0 with phase high, and restart
// (a PERIOD write) re-aligns the blink from the start of a half-period.
module led_blink_prescaler #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic             restart,
  output logic             phase,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             phase_q, phase_d;

  // Next counter/phase; restart wins over a coincident wrap.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (restart || (period == '0)) begin
      count_d = '0;
      phase_d = 1'b1;
    end else if (count_q == period) begin
      count_d = '0;
      phase_d = ~phase_q;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter and phase state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      phase_q <= 1'b1;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
  assign count = count_q;

endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM LED output PIO with atomic set/clear, per-channel blink mode and
// a programmable blink prescaler. Zero-wait-state slave, combinational read.
// Optional feature: define LED_PIO_TOGGLE_EN to enable the TOGGLE register
// at address 6 (DATA ^= writedata); otherwise address 6 is reserved.
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int unsigned WIDTH          = 5,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned DEFAULT_PERIOD = 12499999
) (
  input  logic             clk,
  input  logic             reset,
  input  led_addr_t        address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic             period_wr;
  logic             phase;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   status;
  logic             unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wdata     = writedata[WIDTH-1:0];
  assign period_wr = wr_en && (address == LED_ADDR_PERIOD);
  // Upper write bits beyond WIDTH are intentionally dropped.
  assign unused_wdata = ^writedata;

  // Register-file next state for the single write per cycle.
  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        LED_ADDR_DATA:   data_d   = wdata;
        LED_ADDR_SET:    data_d   = data_q | wdata;
        LED_ADDR_CLR:    data_d   = data_q & ~wdata;
        LED_ADDR_MODE:   mode_d   = wdata;
        LED_ADDR_PERIOD: period_d = writedata[CNT_W-1:0];
`ifdef LED_PIO_TOGGLE_EN
        LED_ADDR_TOGGLE: data_d   = data_q ^ wdata;
`endif
        default: ;
      endcase
    end
  end

  // Register file with synchronous reset taking priority over writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      mode_q   <= '0;
      period_q <= CNT_W'(DEFAULT_PERIOD);
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      period_q <= period_d;
    end
  end

  led_blink_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .period  (period_q),
    .restart (period_wr),
    .phase   (phase),
    .count   (count)
  );

  assign status = {count, phase};

  // Combinational read mux; write-only and reserved addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      LED_ADDR_DATA:   readdata[WIDTH-1:0] = data_q;
      LED_ADDR_MODE:   readdata[WIDTH-1:0] = mode_q;
      LED_ADDR_PERIOD: readdata[CNT_W-1:0] = period_q;
      LED_ADDR_STATUS: readdata            = 32'(status);
      default:         readdata            = '0;
    endcase
  end

  // Blink channels are gated by phase; static channels follow DATA.
  assign out_port = data_q & (~mode_q | {WIDTH{phase}});

endmodule

// File: tb/tb_led_pio_blink.sv
// Scoreboard bench for led_pio_blink (WIDTH=5, CNT_W=8, DEFAULT_PERIOD=3).
// The driver pushes expected readdata/out_port and raises mon_req; the
// monitor pops and compares on the falling edge.
module tb_led_pio_blink;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [4:0]  out_port;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic [4:0]  o;
  } exp_t;

  exp_t sb[$];
  logic mon_req = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  led_pio_blink #(
    .WIDTH          (5),
    .CNT_W          (8),
    .DEFAULT_PERIOD (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Monitor: pops one expectation per requested sample.
  always @(negedge clk) begin
    if (mon_req) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL monitor: sample requested with empty scoreboard");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (readdata !== e.rd || out_port !== e.o) begin
          n_err++;
          $display("FAIL %s: readdata=%h out_port=%h, expected readdata=%h out_port=%h",
                   e.nm, readdata, out_port, e.rd, e.o);
        end
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input logic [2:0] a, input logic [31:0] erd, input logic [4:0] eo,
                     input string nm);
    exp_t e;
    e.nm = nm;
    e.rd = erd;
    e.o  = eo;
    sb.push_back(e);
    address = a;
    mon_req = 1'b1;
    @(posedge clk);
    #1;
    mon_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] reset_rd [8];
    reset_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'h1, 32'h0, 32'h0};
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    @(posedge clk);
    #1;

    // Reset held: every address reads its reset value.
    for (int i = 0; i < 8; i++) chk(3'(i), reset_rd[i], 5'h00, $sformatf("reset_rd%0d", i));
    reset = 1'b0;

    // DATA, SET, CLR.
    wr(3'd0, 32'h3F);
    chk(3'd0, 32'h1F, 5'h1F, "data_wr_3f");
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h05);
    chk(3'd0, 32'h1A, 5'h1A, "clr_05");
    wr(3'd1, 32'h01);
    chk(3'd0, 32'h1B, 5'h1B, "set_01");
    chk(3'd1, 32'h00, 5'h1B, "set_reads_0");
    chk(3'd2, 32'h00, 5'h1B, "clr_reads_0");

    // Blink on channels 1:0 with PERIOD=3: 4 cycles on, 4 off.
    wr(3'd0, 32'h1F);
    wr(3'd3, 32'h03);
    wr(3'd4, 32'h03);
    for (int i = 0; i < 16; i++) begin
      int ph;
      ph = ((i / 4) % 2 == 0) ? 1 : 0;
      chk(3'd5, 32'(((i % 4) << 1) | ph), (ph == 1) ? 5'h1F : 5'h1C, $sformatf("blink%0d", i));
    end
    chk(3'd3, 32'h03, 5'h1F, "mode_rd");

    // PERIOD=0 parks phase high.
    wr(3'd4, 32'h00);
    for (int i = 0; i < 4; i++) chk(3'd5, 32'h01, 5'h1F, $sformatf("period0_%0d", i));

    // PERIOD=1 written on the wrap edge of a PERIOD=3 half-period.
    wr(3'd4, 32'h03);
    chk(3'd5, 32'h01, 5'h1F, "pre_wrap0");
    chk(3'd5, 32'h03, 5'h1F, "pre_wrap1");
    chk(3'd5, 32'h05, 5'h1F, "pre_wrap2");
    wr(3'd4, 32'h01);
    chk(3'd5, 32'h01, 5'h1F, "wrap_restart");
    chk(3'd5, 32'h03, 5'h1F, "wrap_p1");
    chk(3'd5, 32'h00, 5'h1C, "wrap_inv");
    chk(3'd5, 32'h02, 5'h1C, "wrap_p3");
    chk(3'd5, 32'h01, 5'h1F, "wrap_p4");
    chk(3'd4, 32'h01, 5'h1F, "period_rd1");

    // Reset coincident with a DATA write.
    reset      = 1'b1;
    address    = 3'd0;
    writedata  = 32'h1F;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    chk(3'd5, 32'h01, 5'h00, "rst_status");
    chk(3'd0, 32'h00, 5'h00, "rst_data");
    chk(3'd3, 32'h00, 5'h00, "rst_mode");
    chk(3'd4, 32'h03, 5'h00, "rst_period");

    // TOGGLE at address 6.
    wr(3'd0, 32'h0A);
    wr(3'd6, 32'h0F);
`ifdef LED_PIO_TOGGLE_EN
    chk(3'd6, 32'h00, 5'h05, "toggle_rd6");
    chk(3'd0, 32'h05, 5'h05, "toggle_data");
`else
    chk(3'd6, 32'h00, 5'h0A, "toggle_rd6");
    chk(3'd0, 32'h0A, 5'h0A, "toggle_data");
`endif

    // Upper bits dropped; address 7 writes ignored.
    wr(3'd0, 32'hFFFF_FFEA);
    chk(3'd0, 32'h0A, 5'h0A, "data_upper");
    wr(3'd3, 32'hFFFF_FFE0);
    chk(3'd3, 32'h00, 5'h0A, "mode_upper");
    wr(3'd7, 32'hFF);
    chk(3'd7, 32'h00, 5'h0A, "rsvd_rd");
    chk(3'd0, 32'h0A, 5'h0A, "rsvd_nowr");

    @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pio_blink.md
# led_pio_blink

Parametrised Avalon-MM output PIO for board LEDs, succeeding the fixed 5-bit LED register in the Qsys system. It adds atomic set/clear access, a per-channel blink mode and a programmable blink prescaler. It sits on the system interconnect as a zero-wait-state slave and drives `out_port` straight to the LED pins.

## Interface
Parameters:
- `WIDTH`, 5: number of LED channels, 1..32.
- `CNT_W`, 24: prescaler counter and PERIOD register width, 1..32.
- `DEFAULT_PERIOD`, 12499999: PERIOD value after reset. At 50 MHz this gives a 2 Hz blink.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `address`, in, 3: word address.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: read data. Combinational, zero wait states.
- `out_port`, out, WIDTH: LED drive.

## Operation
- A write is `chipselect && !write_n`. There is at most one write per cycle.
- Register map. Only bits [WIDTH-1:0] are stored; upper write bits are ignored and read as 0.
  - 0 DATA, RW: write replaces DATA.
  - 1 SET, WO: DATA |= writedata. Reads 0.
  - 2 CLR, WO: DATA &= ~writedata. Reads 0.
  - 3 MODE, RW: bit i=1 puts channel i in blink mode.
  - 4 PERIOD, RW, CNT_W bits: blink half-period minus 1, in clk cycles.
  - 5 STATUS, RO: bit0 = phase, bits[CNT_W:1] = counter value.
  - 6 TOGGLE, WO: present only with the macro; see Configuration.
  - 7: reads 0, writes ignored.
- Output: `out_port[i] = DATA[i] & (~MODE[i] | phase)`. Static channels follow DATA; blink channels show DATA gated by phase.
- Prescaler:
  - When PERIOD != 0: if counter == PERIOD, the counter goes to 0 and phase inverts; otherwise the counter increments.
  - When PERIOD == 0: counter held at 0, phase held at 1, so blink channels are steadily on.
- Write to PERIOD: counter←0 and phase←1 in the same cycle as the register update. This overrides a coincident wrap.
- Writing PERIOD to a value below the current counter value has no separate effect, because the restart above always applies.
- Reset values: DATA=0, MODE=0, PERIOD=DEFAULT_PERIOD, counter=0, phase=1. Therefore `out_port`=0 and `readdata` is defined by `address` alone.
- Reset has priority over any write in the same cycle.
- Reset asserted mid-blink returns all state to reset values on the next edge.

## Timing
- Write latency: a register update is visible in `readdata` and `out_port` on the cycle after the write edge.
- `out_port` is combinational from registered DATA, MODE and phase; there are no extra pipeline stages.
- Blink: phase inverts every PERIOD+1 cycles, so the full blink period is 2·(PERIOD+1) cycles.
- Following a PERIOD write at edge k, the first phase inversion occurs at edge k+PERIOD+1.
- Read latency is 0; `readdata` is valid in the same cycle as `address`. Reads have no side effects.

## Configuration
- `LED_PIO_TOGGLE_EN`
  - Defined: address 6 is TOGGLE (WO, reads 0); a write does DATA ^= writedata.
  - Undefined: address 6 behaves like address 7 (reads 0, writes ignored).

## Structure
- Package `led_pio_pkg`: register address constants `LED_ADDR_DATA` … `LED_ADDR_TOGGLE` and the 3-bit address typedef.
- Sub-module `led_blink_prescaler`:
  - Inputs: `clk`, `reset`, `period`, `restart`.
  - Outputs: `phase`, `count`.
  - Parameter: `CNT_W`.
  - Contains the counter/phase logic.
- The top level holds the register file, read mux and output gating.

## Test plan
All scenarios use WIDTH=5, CNT_W=8, DEFAULT_PERIOD=3.
- Reset then read every address → all reads 0 except PERIOD=3 and STATUS=0x01; `out_port`=0.
- Write DATA=0x3F → DATA reads 0x1F and `out_port`=0x1F. Then SET 0x00, CLR 0x05 → `out_port`=0x1A; SET 0x01 → 0x1B.
- DATA=0x1F, MODE=0x03 → bits[4:2] stay 1; bits[1:0] are 1 for 4 cycles, then 0 for 4 cycles, repeating. Write PERIOD=0 → `out_port`=0x1F steady.
- While blinking, write PERIOD=1 in the cycle the counter would wrap → next cycle STATUS=0x01; phase inverts 2 edges later.
- Assert `reset` for 1 cycle together with a DATA=0x1F write → `out_port`=0 and all registers at reset values.
- With `LED_PIO_TOGGLE_EN`: DATA=0x0A, TOGGLE 0x0F → `out_port`=0x05. Without it, the same TOGGLE write leaves `out_port`=0x0A and address 6 reads 0.
